seq_divider: RTL and testbench

Iterative unsigned restoring divider. It is the inverse arithmetic unit to the multiplier-adder exercise: Q = A / B and R = A mod B.
- One quotient bit is produced per clock, so a result takes N cycles.
- On the board, operands come from switch-loaded registers, the clock from KEY1 and Resetn from KEY0.
- Results drive the hex7seg displays.

---
 rtl/seq_divider.sv | 113 +++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: Quotient = Dividend / Divisor and
// Remainder = Dividend mod Divisor. It produces one quotient bit per clock.
module seq_divider #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [M-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [M-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  dq_q;
  logic [M:0]    p_q;
  logic [M-1:0]  dv_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  quot_q;
  logic [M-1:0]  rem_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  logic [M:0]    p_sh;
  logic [M:0]    p_d;
  logic [N-1:0]  dq_d;

  // One restoring step: shift the next dividend bit into P, then subtract if it fits.
  always_comb begin
    p_sh = {p_q[M-1:0], dq_q[N-1]};
    p_d  = p_sh;
    dq_d = {dq_q[N-2:0], 1'b0};
    if (p_sh >= {1'b0, dv_q}) begin
      p_d  = p_sh - {1'b0, dv_q};
      dq_d = {dq_q[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      p_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            if (Divisor == '0) begin
              // A zero divisor completes immediately with a saturated quotient.
              state_q <= S_DONE;
              quot_q  <= '1;
              rem_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              dq_q    <= Dividend;
              dv_q    <= Divisor;
              p_q     <= '0;
              cnt_q   <= CW'(N);
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              dbz_q   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          dq_q  <= dq_d;
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          // The step that empties the counter also publishes the result.
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            quot_q  <= dq_d;
            rem_q   <= p_d[M-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain integer division.
module tb_seq_divider;

  localparam int unsigned N = 16;
  localparam int unsigned M = 8;

  logic         Clock;
  logic         Resetn;
  logic         Start;
  logic [N-1:0] Dividend;
  logic [M-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [M-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  int vectors;
  int miscompares;
  logic [N-1:0] exp_q;
  logic [M-1:0] exp_r;

  seq_divider #(.N(N), .M(M)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one request through all N steps; optionally pokes a Start during RUN.
  task automatic do_op(input logic [N-1:0] a, input logic [M-1:0] b, input int poke);
    logic [N-1:0] eq;
    logic [M-1:0] er;
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    tick();
    Start    = 1'b0;
    Dividend = N'($urandom);
    Divisor  = M'($urandom);
    if (b == '0) begin
      exp_q = '1;
      exp_r = '0;
      check("dz_done", 32'(Done), 32'd1);
      check("dz_flag", 32'(DivByZero), 32'd1);
      check("dz_busy", 32'(Busy), 32'd0);
      check("dz_quot", 32'(Quotient), 32'(exp_q));
      check("dz_rem", 32'(Remainder), 32'(exp_r));
      tick();
      check("dz_hold_busy", 32'(Busy), 32'd0);
      check("dz_hold_done", 32'(Done), 32'd1);
      return;
    end
    eq = a / b;
    er = a % b;
    check("acc_busy", 32'(Busy), 32'd1);
    check("acc_done", 32'(Done), 32'd0);
    check("acc_dz", 32'(DivByZero), 32'd0);
    for (int e = 1; e <= int'(N); e++) begin
      if (e == poke) begin
        Start    = 1'b1;
        Dividend = 16'd50;
        Divisor  = 8'd5;
      end
      tick();
      Start = 1'b0;
      if (e < int'(N)) begin
        check("run_busy", 32'(Busy), 32'd1);
        check("run_done", 32'(Done), 32'd0);
        check("run_hold_q", 32'(Quotient), 32'(exp_q));
        check("run_hold_r", 32'(Remainder), 32'(exp_r));
      end
    end
    exp_q = eq;
    exp_r = er;
    check("cmp_done", 32'(Done), 32'd1);
    check("cmp_busy", 32'(Busy), 32'd0);
    check("cmp_dz", 32'(DivByZero), 32'd0);
    check("cmp_quot", 32'(Quotient), 32'(exp_q));
    check("cmp_rem", 32'(Remainder), 32'(exp_r));
  endtask

  initial begin
    int cnt;
    logic [N-1:0] a;
    logic [M-1:0] b;
    vectors     = 0;
    miscompares = 0;
    exp_q       = '0;
    exp_r       = '0;
    Resetn      = 1'b0;
    Start       = 1'b0;
    Dividend    = '0;
    Divisor     = '0;
    tick();
    tick();
    check("rst_quot", 32'(Quotient), 32'd0);
    check("rst_rem", 32'(Remainder), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dz", 32'(DivByZero), 32'd0);
    Resetn = 1'b1;
    tick();
    check("idle_done", 32'(Done), 32'd0);

    do_op(16'd1000, 8'd7, 0);
    check("t1_q142", 32'(Quotient), 32'd142);
    check("t1_r6", 32'(Remainder), 32'd6);
    do_op(16'hFFFF, 8'hFF, 0);
    check("t2_q0101", 32'(Quotient), 32'h0101);
    do_op(16'd5, 8'd10, 0);
    do_op(16'h1234, 8'd1, 0);
    do_op(16'd1234, 8'd0, 0);
    do_op(16'd9, 8'd2, 0);
    do_op(16'd1000, 8'd7, 5);
    check("t4_q142", 32'(Quotient), 32'd142);

    // Reset in the middle of an operation.
    Dividend = 16'd1000;
    Divisor  = 8'd7;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    repeat (7) tick();
    Resetn = 1'b0;
    tick();
    exp_q = '0;
    exp_r = '0;
    check("mrst_quot", 32'(Quotient), 32'd0);
    check("mrst_rem", 32'(Remainder), 32'd0);
    check("mrst_busy", 32'(Busy), 32'd0);
    check("mrst_done", 32'(Done), 32'd0);
    check("mrst_dz", 32'(DivByZero), 32'd0);
    Resetn = 1'b1;
    tick();
    check("mrst_idle_busy", 32'(Busy), 32'd0);
    do_op(16'd100, 8'd9, 0);

    // Back-to-back sweep with Start held high.
    Start = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      a = N'($urandom_range(0, 65535));
      b = M'($urandom_range(1, 255));
      Dividend = a;
      Divisor  = b;
      tick();
      Dividend = N'($urandom);
      Divisor  = M'($urandom);
      cnt = 0;
      while (!Done && cnt < 40) begin
        tick();
        cnt++;
      end
      check("sw_spacing", 32'(cnt), 32'd16);
      check("sw_invariant", 32'(int'(Quotient) * int'(b) + int'(Remainder)), 32'(a));
      check("sw_rem_lt", 32'(Remainder < b), 32'd1);
      check("sw_quot", 32'(Quotient), 32'(a / b));
      check("sw_busy", 32'(Busy), 32'd0);
    end
    Start = 1'b0;
    tick();
    check("end_done", 32'(Done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
